// File: rtl/seq_subtractor_16b.sv
// Nibble-serial 16-bit subtractor: diff = in1 - in2 - b_in over four cycles, start/done handshake.
// Optional macro SEQ_SUB_SAT_EN saturates diff on signed overflow.
module seq_subtractor_16b #(
    parameter int unsigned NIB_W = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] diff,
    output logic        b_out,
    output logic        overflow
);

    localparam int unsigned DataW   = 16;
    localparam int unsigned NumNib  = DataW / NIB_W;
    localparam logic [1:0]  LastNib = 2'(NumNib - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [DataW-1:0]  a_q, a_d;
    logic [DataW-1:0]  b_q, b_d;
    logic [1:0]        k_q, k_d;
    logic              borrow_q, borrow_d;
    logic [DataW-1:0]  diff_q, diff_d;
    logic              b_out_q, b_out_d;
    logic              ovf_q, ovf_d;

    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [NIB_W:0]    nib_sum;
    logic              ovf_calc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
        end
    end

    // Subtraction as addition: a + ~b + ~borrow, next borrow is the inverted carry.
    always_comb begin
        a_nib   = a_q[k_q*NIB_W +: NIB_W];
        b_nib   = b_q[k_q*NIB_W +: NIB_W];
        nib_sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {{NIB_W{1'b0}}, ~borrow_q};
        ovf_calc = (a_q[DataW-1] != b_q[DataW-1]) && (nib_sum[NIB_W-1] != a_q[DataW-1]);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d      = in1;
                    b_d      = in2;
                    borrow_d = b_in;
                    k_d      = '0;
                    state_d  = StRun;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRun: begin
                diff_d[k_q*NIB_W +: NIB_W] = nib_sum[NIB_W-1:0];
                borrow_d = ~nib_sum[NIB_W];
                k_d      = k_q + 2'd1;
                if (k_q == LastNib) begin
                    b_out_d = ~nib_sum[NIB_W];
                    ovf_d   = ovf_calc;
`ifdef SEQ_SUB_SAT_EN
                    // Clamp toward the minuend's sign; flags still describe the wrapped result.
                    if (ovf_calc) begin
                        diff_d = a_q[DataW-1] ? 16'h8000 : 16'h7FFF;
                    end
`endif
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign diff     = diff_q;
    assign b_out    = b_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_subtractor_16b.sv
// Self-checking bench for seq_subtractor_16b: directed table, handshake corner cases, random vs model.
module tb_seq_subtractor_16b;

`ifdef SEQ_SUB_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        b_in = 1'b0;
    logic        busy, done, b_out, overflow;
    logic [15:0] diff;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seq_subtractor_16b dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .b_out    (b_out),
        .overflow (overflow)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 17-bit arithmetic on the operands.
    function automatic vec_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        vec_t        v;
        logic [16:0] full;
        full = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        v.x  = x;
        v.y  = y;
        v.bi = bi;
        v.d  = full[15:0];
        v.bo = ({1'b0, x} < ({1'b0, y} + {16'd0, bi}));
        v.ov = (x[15] != y[15]) && (full[15] != x[15]);
        if (Sat && v.ov) v.d = x[15] ? 16'h8000 : 16'h7FFF;
        return v;
    endfunction

    task automatic run_op(input string tag, input vec_t v);
        int lat;
        int busy_cnt;
        @(negedge clock);
        in1 = v.x; in2 = v.y; b_in = v.bi; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, " done_low_after_start"}, 32'(done), 32'd0);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 10) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " diff"}, 32'(diff), 32'(v.d));
        chk({tag, " b_out"}, 32'(b_out), 32'(v.bo));
        chk({tag, " overflow"}, 32'(overflow), 32'(v.ov));
        @(negedge clock);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " diff_hold"}, 32'(diff), 32'(v.d));
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, Sat ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, Sat ? 16'h7FFF : 16'h8000, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset b_out", 32'(b_out), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

        // Start during RUN is ignored; start in the DONE cycle is accepted.
        @(negedge clock);
        in1 = 16'h0009; in2 = 16'h0004; b_in = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        in1 = 16'h0100; in2 = 16'h0001; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("ignore busy_mid", 32'(busy), 32'd1);
        @(negedge clock);
        chk("ignore done_early", 32'(done), 32'd0);
        @(negedge clock);
        chk("ignore done", 32'(done), 32'd1);
        chk("ignore diff", 32'(diff), 32'h0005);
        chk("ignore b_out", 32'(b_out), 32'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("b2b done_low", 32'(done), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        begin
            int lat;
            lat = 0;
            while (!done && lat < 10) begin
                @(negedge clock);
                lat++;
            end
            chk("b2b latency", 32'(lat), 32'd4);
            chk("b2b diff", 32'(diff), 32'h00FF);
        end
        @(negedge clock);

        // Asynchronous reset mid-RUN aborts the operation.
        @(negedge clock);
        in1 = 16'h1234; in2 = 16'h0111; b_in = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort diff", 32'(diff), 32'd0);
        chk("abort b_out", 32'(b_out), 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                if (done) dones++;
            end
            chk("abort no_done", 32'(dones), 32'd0);
        end
        run_op("post_reset", model(16'h4321, 16'h1111, 1'b1));

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            logic        bi;
            x  = 16'($urandom);
            y  = 16'($urandom);
            bi = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), model(x, y, bi));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_subtractor_16b.md
Name: seq_subtractor_16b

Overview:
- Multi-cycle 16-bit two's-complement subtractor, nibble-serial, with a start/done handshake.
- It is the inverse-direction companion to the 16-bit ripple-carry adder in the execute path.
- It computes in1 - in2 - b_in using one 4-bit borrow slice per cycle. Borrow and signed-overflow flags use the adder's flag conventions.
- Intended for the SUB/CMP path, where a registered multi-cycle result is acceptable.

Parameters:
- NIB_W, 4, width of the per-cycle slice. Fixed at 4; the data width is fixed at 16, giving 4 iterations.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Operands are sampled on the edge where start=1 and the block is not busy.
- in1  input  16  minuend.
- in2  input  16  subtrahend.
- b_in  input  1  borrow-in, subtracted in addition to in2.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; the result outputs are valid from this cycle.
- diff  output  16  result, in1 - in2 - b_in mod 2^16.
- b_out  output  1  unsigned borrow out; 1 iff in1 < in2 + b_in, compared as unsigned.
- overflow  output  1  signed overflow; 1 iff in1[15] != in2[15] and wrapped diff[15] != in1[15].

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, diff=0, b_out=0, overflow=0. Internal operand, nibble-index and borrow registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E0:
  - latch in1, in2 and b_in;
  - set nibble index k=0 and internal borrow = b_in;
  - enter RUN with busy=1;
  - done is low in the cycle after E0.
- RUN, edges E1..E4: edge Ek+1 computes nibble k = a[k] + ~b[k] + ~borrow, producing a 4-bit result and a carry. It writes diff[4k+3:4k] and sets borrow = ~carry.
- At E4 (k=3):
  - b_out = final borrow;
  - overflow is computed from the operand signs and the wrapped diff[15];
  - state moves to DONE, done=1, busy=0.
- Latency: done is high in the cycle following E4, i.e. 4 clocks after the start-sampling edge.
- DONE lasts one cycle; done returns to 0 on the next edge.
- diff, b_out and overflow hold their values until the next accepted start. Diff nibbles are overwritten progressively during the next RUN; they are not valid until done.
- start while in RUN (busy=1) is ignored, with no queuing. The operands in flight are unaffected.
- start=1 in the DONE cycle is accepted: back-to-back operation, next done 4 clocks later.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and outputs return to reset values.
- Arithmetic is always modulo 2^16. b_in=1 with in2=0xFFFF produces b_out=1 and is not special-cased.

Optional Feature:
- Macro: SEQ_SUB_SAT_EN.
- When defined, and overflow=1 at completion, diff is saturated:
  - 0x7FFF if in1[15]=0;
  - 0x8000 if in1[15]=1.
- overflow and b_out are still reported from the unsaturated computation.
- Saturation is applied at the E4 edge, so latency is unchanged.
- When undefined, diff is always the wrapped result.

Test Plan:
- Reset, then in1=0x0005, in2=0x0003, b_in=0, start pulse -> done exactly 4 clocks after the sampling edge; diff=0x0002, b_out=0, overflow=0; busy high for 4 cycles.
- in1=0x0000, in2=0x0001 -> diff=0xFFFF, b_out=1, overflow=0. Then in1=0x1000, in2=0x0FFF, b_in=1 -> diff=0x0000, b_out=0.
- in1=0x8000, in2=0x0001 -> overflow=1, b_out=0; diff=0x7FFF without SEQ_SUB_SAT_EN, diff=0x8000 with it.
- in1=0x7FFF, in2=0xFFFF -> overflow=1, b_out=1; diff=0x8000 without the macro, diff=0x7FFF with it.
- Mid-operation start is ignored:
  - start with 0x0009-0x0004;
  - pulse start again 2 cycles later with 0x0100-0x0001;
  - expected: a single done, diff=0x0005;
  - a start in the DONE cycle with 0x0100-0x0001 gives diff=0x00FF 4 clocks later.
- Reset mid-operation:
  - assert reset 2 cycles into RUN;
  - expected: all outputs 0 immediately (asynchronous), no done pulse;
  - a new start after reset release completes normally.
